// File: rtl/data_mem_responder.sv
// data_mem_responder
// Responder end of the core's data-memory port. Array stores are posted into
// a small FIFO write buffer and drained one entry per cycle into a
// word-addressed RAM. Loads forward from the buffer, newest entry first.
// There is also one memory-mapped LED register and a sticky unmapped-store
// flag.
module data_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0800,
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned WBUF_DEPTH  = 4,
    parameter logic [31:0] LED_ADDR    = 32'h0000_0C00,
    localparam int unsigned AW = $clog2(DEPTH_WORDS),
    localparam int unsigned PW = $clog2(WBUF_DEPTH)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [31:0]   Addr,
    input  logic [31:0]   WriteData,
    input  logic          MemWrite,
    output logic [31:0]   ReadData,
    input  logic          HOLD,
    input  logic [AW-1:0] DBG_ADDR,
    output logic [31:0]   DBG_DATA,
    output logic [7:0]    LED,
    output logic [PW:0]   WBUF_COUNT,
    output logic          WBUF_FULL,
    output logic          OOR_ERR
);

    localparam logic [29:0] BASE_W  = BASE_ADDR[31:2];
    localparam logic [29:0] LIMIT_W = BASE_W + 30'(DEPTH_WORDS);
    localparam logic [29:0] LED_W   = LED_ADDR[31:2];

    logic [31:0]   r_mem     [DEPTH_WORDS];
    logic [AW-1:0] r_wb_idx  [WBUF_DEPTH];
    logic [31:0]   r_wb_data [WBUF_DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic [7:0]    r_led;
    logic          r_oor;

    logic [29:0]   w_word;
    logic [AW-1:0] w_idx;
    logic          w_in_array;
    logic          w_is_led;
    logic          w_full;
    logic          w_enq;
    logic          w_drain;
    logic          w_fwd_hit;
    logic [31:0]   w_fwd_data;
    logic          w_unused_addr_lsbs;

    // Byte lanes are not supported, so the low address bits are don't-care.
    assign w_unused_addr_lsbs = ^Addr[1:0];

    assign w_word     = Addr[31:2];
    assign w_in_array = (w_word >= BASE_W) && (w_word < LIMIT_W);
    assign w_is_led   = (w_word == LED_W);
    assign w_idx      = AW'(w_word - BASE_W);

    assign w_full  = (r_count == (PW+1)'(WBUF_DEPTH));
    assign w_enq   = MemWrite && w_in_array;
    // A full buffer drains regardless of HOLD so an incoming store is never lost.
    assign w_drain = (r_count != '0) && (!HOLD || w_full);

    // Buffer pointers and occupancy; reset discards pending stores.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq)
                r_tail <= r_tail + PW'(1);
            if (w_drain)
                r_head <= r_head + PW'(1);
            r_count <= r_count + (PW+1)'(w_enq) - (PW+1)'(w_drain);
        end
    end

    // Buffer payload storage; only entries inside the count are ever read.
    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_wb_idx[r_tail]  <= w_idx;
            r_wb_data[r_tail] <= WriteData;
        end
    end

    // Array write port fed by the buffer head; contents survive reset.
    always_ff @(posedge CLK) begin
        if (w_drain)
            r_mem[r_wb_idx[r_head]] <= r_wb_data[r_head];
    end

    // LED register and sticky unmapped-store flag.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_led <= '0;
            r_oor <= 1'b0;
        end else if (MemWrite) begin
            if (w_is_led && !w_in_array)
                r_led <= WriteData[7:0];
            if (!w_in_array && !w_is_led)
                r_oor <= 1'b1;
        end
    end

    // Forwarding search, oldest to newest, so the newest matching entry wins.
    always_comb begin
        logic [PW-1:0] slot;
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        slot       = '0;
        for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
            slot = r_head + PW'(i);
            if (((PW+1)'(i) < r_count) && (r_wb_idx[slot] == w_idx)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_wb_data[slot];
            end
        end
    end

    // Load data mux: array (with forwarding), LED register, or zero.
    always_comb begin
        ReadData = '0;
        if (w_in_array)
            ReadData = w_fwd_hit ? w_fwd_data : r_mem[w_idx];
        else if (w_is_led)
            ReadData = {24'b0, r_led};
    end

    assign DBG_DATA   = r_mem[DBG_ADDR];
    assign LED        = r_led;
    assign WBUF_COUNT = r_count;
    assign WBUF_FULL  = w_full;
    assign OOR_ERR    = r_oor;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (default parameters).
module tb_data_mem_responder;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] Addr = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic [31:0] ReadData;
    logic        HOLD = 1'b0;
    logic [6:0]  DBG_ADDR = '0;
    logic [31:0] DBG_DATA;
    logic [7:0]  LED;
    logic [2:0]  WBUF_COUNT;
    logic        WBUF_FULL;
    logic        OOR_ERR;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_responder #(
        .BASE_ADDR   (32'h0000_0800),
        .DEPTH_WORDS (128),
        .WBUF_DEPTH  (4),
        .LED_ADDR    (32'h0000_0C00)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .Addr       (Addr),
        .WriteData  (WriteData),
        .MemWrite   (MemWrite),
        .ReadData   (ReadData),
        .HOLD       (HOLD),
        .DBG_ADDR   (DBG_ADDR),
        .DBG_DATA   (DBG_DATA),
        .LED        (LED),
        .WBUF_COUNT (WBUF_COUNT),
        .WBUF_FULL  (WBUF_FULL),
        .OOR_ERR    (OOR_ERR)
    );

    always #5 CLK = ~CLK;

    // Advance past the next rising edge; inputs and checks happen here.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        Addr      = a;
        WriteData = d;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        RESET = 1'b0;
        tick();
        chk("rst_count", 32'(WBUF_COUNT), 32'd0);
        chk("rst_full",  32'(WBUF_FULL),  32'd0);
        chk("rst_led",   32'(LED),        32'd0);
        chk("rst_oor",   32'(OOR_ERR),    32'd0);

        // 1: store then forward, then drained into the array
        store(32'h800, 32'hDEADBEEF);
        chk("t1_count1", 32'(WBUF_COUNT), 32'd1);
        chk("t1_fwd",    ReadData,        32'hDEADBEEF);
        tick();
        DBG_ADDR = 7'd0;
        #1;
        chk("t1_count0", 32'(WBUF_COUNT), 32'd0);
        chk("t1_dbg0",   DBG_DATA,        32'hDEADBEEF);
        chk("t1_arr_rd", ReadData,        32'hDEADBEEF);

        // 2: known value in word 1, then HOLD with repeated stores
        store(32'h804, 32'h5555_0001);
        tick();
        HOLD = 1'b1;
        store(32'h804, 32'h11);
        store(32'h804, 32'h22);
        store(32'h808, 32'h33);
        Addr     = 32'h804;
        DBG_ADDR = 7'd1;
        #1;
        chk("t2_count3", 32'(WBUF_COUNT), 32'd3);
        chk("t2_newest", ReadData,        32'h22);
        chk("t2_dbg1_held", DBG_DATA,     32'h5555_0001);
        Addr = 32'h808;
        #1;
        chk("t2_fwd808", ReadData,        32'h33);
        HOLD = 1'b0;
        tick();
        chk("t2_count2", 32'(WBUF_COUNT), 32'd2);
        chk("t2_dbg1_a", DBG_DATA,        32'h11);
        tick();
        tick();
        chk("t2_count0", 32'(WBUF_COUNT), 32'd0);
        chk("t2_dbg1_b", DBG_DATA,        32'h22);
        DBG_ADDR = 7'd2;
        #1;
        chk("t2_dbg2",   DBG_DATA,        32'h33);

        // 3: fill the buffer under HOLD, fifth store forces a drain
        HOLD = 1'b1;
        for (int k = 0; k < 4; k++)
            store(32'h840 + 32'(4 * k), 32'h100 + 32'(k));
        chk("t3_count4", 32'(WBUF_COUNT), 32'd4);
        chk("t3_full",   32'(WBUF_FULL),  32'd1);
        store(32'h850, 32'h104);
        DBG_ADDR = 7'd16;
        #1;
        chk("t3_count4b", 32'(WBUF_COUNT), 32'd4);
        chk("t3_full_b",  32'(WBUF_FULL),  32'd1);
        chk("t3_dbg16",   DBG_DATA,        32'h100);
        tick();
        DBG_ADDR = 7'd17;
        #1;
        chk("t3_count3",  32'(WBUF_COUNT), 32'd3);
        chk("t3_dbg17",   DBG_DATA,        32'h101);
        tick();
        chk("t3_hold3",   32'(WBUF_COUNT), 32'd3);
        Addr = 32'h84C;
        #1;
        chk("t3_fwd19",   ReadData,        32'h103);
        Addr = 32'h850;
        #1;
        chk("t3_fwd20",   ReadData,        32'h104);
        HOLD = 1'b0;
        tick();
        tick();
        tick();
        chk("t3_count0",  32'(WBUF_COUNT), 32'd0);
        for (int k = 18; k <= 20; k++) begin
            DBG_ADDR = 7'(k);
            #1;
            chk("t3_dbg_tail", DBG_DATA, 32'h100 + 32'(k - 16));
        end

        // Top array word boundary and first address past the array
        store(32'h9FC, 32'hCAFE_F00D);
        tick();
        DBG_ADDR = 7'd127;
        #1;
        chk("b_dbg127",  DBG_DATA, 32'hCAFE_F00D);
        chk("b_rd9fc",   ReadData, 32'hCAFE_F00D);
        Addr = 32'hA00;
        #1;
        chk("b_rdA00",   ReadData, 32'h0);

        // 4: LED register, only low byte kept
        store(32'hC00, 32'hFFFF_FFA5);
        chk("t4_led",    32'(LED),        32'hA5);
        chk("t4_rd",     ReadData,        32'h0000_00A5);
        chk("t4_count",  32'(WBUF_COUNT), 32'd0);

        // 5: unmapped store sets the sticky flag
        chk("t5_oor_pre", 32'(OOR_ERR),   32'd0);
        store(32'h400, 32'h1234);
        chk("t5_oor",    32'(OOR_ERR),    32'd1);
        chk("t5_count",  32'(WBUF_COUNT), 32'd0);
        chk("t5_rd",     ReadData,        32'h0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        Addr  = 32'h400;
        tick();
        tick();
        chk("t5_load_oor", 32'(OOR_ERR),  32'd0);

        // 6: reset while the buffer is draining
        for (int k = 0; k < 3; k++)
            store(32'h8A0 + 32'(4 * k), 32'h0);
        tick();
        tick();
        store(32'hC00, 32'h3C);
        store(32'h400, 32'h0);
        chk("t6_led_pre", 32'(LED),     32'h3C);
        chk("t6_oor_pre", 32'(OOR_ERR), 32'd1);
        HOLD = 1'b1;
        for (int k = 0; k < 3; k++)
            store(32'h8A0 + 32'(4 * k), 32'hAAA0 + 32'(k));
        chk("t6_count3", 32'(WBUF_COUNT), 32'd3);
        HOLD = 1'b0;
        tick();
        chk("t6_count2", 32'(WBUF_COUNT), 32'd2);
        #2;
        RESET = 1'b1;
        #1;
        chk("t6_rst_count", 32'(WBUF_COUNT), 32'd0);
        chk("t6_rst_led",   32'(LED),        32'd0);
        chk("t6_rst_oor",   32'(OOR_ERR),    32'd0);
        tick();
        RESET = 1'b0;
        tick();
        DBG_ADDR = 7'd40;
        #1;
        chk("t6_dbg40", DBG_DATA, 32'hAAA0);
        DBG_ADDR = 7'd41;
        #1;
        chk("t6_dbg41", DBG_DATA, 32'h0);
        DBG_ADDR = 7'd42;
        #1;
        chk("t6_dbg42", DBG_DATA, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
